// File: rtl/adc_lane_capture.sv
// Purpose: trigger-armed snapshot of DEPTH packed 4x9-bit ADC lane words, replayed one sample per transfer.
// Latency: first sample is valid DEPTH cycles after the trigger cycle; one sample per cycle with RD_READY high.
// Backpressure: RD_READY low holds RD_DATA/RD_LAST indefinitely; RD_VALID never depends on RD_READY.
`timescale 1ns/1ps
module adc_lane_capture #(
    parameter int DEPTH = 64
) (
    input  logic        CLK500M,
    input  logic        RST_N,
    input  logic [35:0] ADC_DATA,
    input  logic        ARM,
    input  logic        TRIG,
    input  logic        ABORT,
    output logic [8:0]  RD_DATA,
    output logic        RD_VALID,
    input  logic        RD_READY,
    output logic        RD_LAST,
    output logic        BUSY,
    output logic        DONE,
    output logic [1:0]  STATE
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_WORD = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_word_q, rd_word_d;
    logic [1:0]      rd_sub_q, rd_sub_d;
    logic            done_q, done_d;

    logic            mem_we;
    logic [PW-1:0]   mem_waddr;
    logic [35:0]     mem [DEPTH];
    logic [35:0]     rd_word_dat;
    logic [8:0]      rd_sample;
    logic            rd_vld;
    logic            rd_last;

    // Read side is purely a function of registered state and pointers plus the array mux.
    always_comb begin
        rd_vld      = (state_q == S_READOUT);
        rd_last     = rd_vld && (rd_word_q == LAST_WORD) && (rd_sub_q == 2'd3);
        rd_word_dat = mem[rd_word_q];
        case (rd_sub_q)
            2'd0:    rd_sample = rd_word_dat[8:0];
            2'd1:    rd_sample = rd_word_dat[17:9];
            2'd2:    rd_sample = rd_word_dat[26:18];
            default: rd_sample = rd_word_dat[35:27];
        endcase
    end

    assign RD_VALID = rd_vld;
    assign RD_DATA  = rd_vld ? rd_sample : 9'd0;
    assign RD_LAST  = rd_last;
    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = done_q;
    assign STATE    = state_q;

    // Next-state, pointer and write-enable logic; ABORT overrides every other request.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_word_d = rd_word_q;
        rd_sub_d  = rd_sub_q;
        done_d    = done_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        if (ABORT) begin
            state_d   = S_IDLE;
            wr_ptr_d  = '0;
            rd_word_d = '0;
            rd_sub_d  = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ARM) begin
                        state_d = S_ARMED;
                        done_d  = 1'b0;
                    end
                end
                S_ARMED: begin
                    if (TRIG) begin
                        mem_we    = 1'b1;
                        mem_waddr = '0;
                        wr_ptr_d  = PW'(1);
                        state_d   = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (wr_ptr_q == LAST_WORD) begin
                        state_d   = S_READOUT;
                        wr_ptr_d  = '0;
                        rd_word_d = '0;
                        rd_sub_d  = 2'd0;
                    end
                end
                default: begin
                    if (RD_READY) begin
                        rd_sub_d = rd_sub_q + 2'd1;
                        if (rd_sub_q == 2'd3) begin
                            rd_word_d = rd_word_q + PW'(1);
                        end
                        if (rd_last) begin
                            state_d   = S_IDLE;
                            done_d    = 1'b1;
                            rd_word_d = '0;
                            rd_sub_d  = 2'd0;
                        end
                    end
                end
            endcase
        end
    end

    // Control state and pointers, cleared asynchronously.
    always_ff @(posedge CLK500M or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_word_q <= '0;
            rd_sub_q  <= 2'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_word_q <= rd_word_d;
            rd_sub_q  <= rd_sub_d;
            done_q    <= done_d;
        end
    end

    // Snapshot storage; contents are only meaningful after a completed capture, so no reset.
    always_ff @(posedge CLK500M) begin
        if (mem_we) begin
            mem[mem_waddr] <= ADC_DATA;
        end
    end

endmodule

// File: tb/tb_adc_lane_capture.sv
`timescale 1ns/1ps
module tb_adc_lane_capture;

    localparam int DEPTH = 4;
    localparam int NSMP  = 4 * DEPTH;

    logic        CLK500M = 1'b0;
    logic        RST_N   = 1'b0;
    logic [35:0] ADC_DATA = '0;
    logic        ARM = 1'b0, TRIG = 1'b0, ABORT = 1'b0, RD_READY = 1'b0;
    logic [8:0]  RD_DATA;
    logic        RD_VALID, RD_LAST, BUSY, DONE;
    logic [1:0]  STATE;

    adc_lane_capture #(.DEPTH(DEPTH)) dut (
        .CLK500M (CLK500M),
        .RST_N   (RST_N),
        .ADC_DATA(ADC_DATA),
        .ARM     (ARM),
        .TRIG    (TRIG),
        .ABORT   (ABORT),
        .RD_DATA (RD_DATA),
        .RD_VALID(RD_VALID),
        .RD_READY(RD_READY),
        .RD_LAST (RD_LAST),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .STATE   (STATE)
    );

    always #1 CLK500M = ~CLK500M;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: mode number, captured words and pending samples as queues.
    int          m_state = 0;
    logic        m_done  = 1'b0;
    logic [35:0] m_cap[$];
    logic [8:0]  m_smp[$];

    // Samples actually accepted by the consumer, with their RD_LAST flags.
    logic [8:0]  got_dat[$];
    logic        got_last[$];

    typedef struct {
        logic        arm, trig, abort, rdy;
        logic [35:0] dat;
        int          st;
        logic        vld;
        logic        done;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] wk(input int base, input int k);
        logic [8:0] s0, s1, s2, s3;
        s0 = 9'(base + 4*k);
        s1 = 9'(base + 4*k + 1);
        s2 = 9'(base + 4*k + 2);
        s3 = 9'(base + 4*k + 3);
        return {s3, s2, s1, s0};
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_done  = 1'b0;
        m_cap.delete();
        m_smp.delete();
    endfunction

    function automatic void model_edge(input logic a, input logic t, input logic ab,
                                       input logic r, input logic [35:0] d);
        if (ab) begin
            m_state = 0;
            m_cap.delete();
            m_smp.delete();
        end else begin
            case (m_state)
                0: if (a) begin m_state = 1; m_done = 1'b0; end
                1: if (t) begin m_cap.delete(); m_cap.push_back(d); m_state = 2; end
                2: begin
                    m_cap.push_back(d);
                    if (m_cap.size() == DEPTH) begin
                        m_smp.delete();
                        foreach (m_cap[w])
                            for (int j = 0; j < 4; j++)
                                m_smp.push_back(m_cap[w][9*j +: 9]);
                        m_state = 3;
                    end
                end
                default: if (r) begin
                    void'(m_smp.pop_front());
                    if (m_smp.size() == 0) begin m_state = 0; m_done = 1'b1; end
                end
            endcase
        end
    endfunction

    task automatic compare_outputs();
        logic       ev;
        logic [8:0] ed;
        ev = (m_state == 3);
        ed = (ev && m_smp.size() > 0) ? m_smp[0] : 9'd0;
        chk("state",    36'(STATE),    36'(m_state));
        chk("busy",     36'(BUSY),     36'(m_state != 0));
        chk("rd_valid", 36'(RD_VALID), 36'(ev));
        chk("rd_data",  36'(RD_DATA),  36'(ed));
        chk("rd_last",  36'(RD_LAST),  36'(ev && m_smp.size() == 1));
        chk("done",     36'(DONE),     36'(m_done));
    endtask

    // One clock: drive inputs away from the edge, advance the model at the edge, check after it.
    task automatic step(input logic a, input logic t, input logic ab, input logic r,
                        input logic [35:0] d);
        ARM = a; TRIG = t; ABORT = ab; RD_READY = r; ADC_DATA = d;
        if (RD_VALID && r && !ab) begin
            got_dat.push_back(RD_DATA);
            got_last.push_back(RD_LAST);
        end
        @(posedge CLK500M);
        model_edge(a, t, ab, r, d);
        #1;
        compare_outputs();
    endtask

    task automatic check_seq(input string name, input int base);
        chk({name, "_count"}, 36'(got_dat.size()), 36'(NSMP));
        for (int i = 0; i < NSMP && i < got_dat.size(); i++) begin
            chk({name, "_data"}, 36'(got_dat[i]), 36'(9'(base + i)));
            chk({name, "_last"}, 36'(got_last[i]), 36'(i == NSMP - 1));
        end
    endtask

    // ARM, TRIG next cycle, capture DEPTH words, then read with given ready pattern.
    task automatic snapshot(input int base, input bit rand_rdy);
        got_dat.delete();
        got_last.delete();
        step(1, 0, 0, 0, '0);
        for (int k = 0; k < DEPTH; k++) step(0, 1, 0, 0, wk(base, k));
        for (int c = 0; c < 400 && got_dat.size() < NSMP; c++)
            step(0, 0, 0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, '0);
    endtask

    initial begin
        // Reset values while reset is held.
        model_reset();
        repeat (3) @(posedge CLK500M);
        #1;
        compare_outputs();
        RST_N = 1'b1;

        // Directed table: ignored inputs, priorities, ARMED abort, trigger-to-valid latency.
        tbl[0]  = '{0,1,0,0,36'd0,     0,0,0};
        tbl[1]  = '{1,0,1,0,36'd0,     0,0,0};
        tbl[2]  = '{1,0,0,0,36'd0,     1,0,0};
        tbl[3]  = '{1,0,0,0,36'd0,     1,0,0};
        tbl[4]  = '{0,0,1,0,36'd0,     0,0,0};
        tbl[5]  = '{1,0,0,0,36'd0,     1,0,0};
        tbl[6]  = '{0,0,0,1,36'd0,     1,0,0};
        tbl[7]  = '{0,1,0,0,wk(0,0),   2,0,0};
        tbl[8]  = '{1,1,0,0,wk(0,1),   2,0,0};
        tbl[9]  = '{0,1,0,0,wk(0,2),   2,0,0};
        tbl[10] = '{0,1,0,0,wk(0,3),   3,1,0};
        got_dat.delete();
        got_last.delete();
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].arm, tbl[i].trig, tbl[i].abort, tbl[i].rdy, tbl[i].dat);
            chk("tbl_state", 36'(STATE),    36'(tbl[i].st));
            chk("tbl_valid", 36'(RD_VALID), 36'(tbl[i].vld));
            chk("tbl_done",  36'(DONE),     36'(tbl[i].done));
        end
        // Basic readout with TRIG held high and an ARM mid-readout.
        for (int c = 0; c < NSMP; c++) step(c == 3, 1, 0, 1, '0);
        chk("basic_done",  36'(DONE),  36'd1);
        chk("basic_state", 36'(STATE), 36'd0);
        check_seq("basic", 0);
        // TRIG still high in IDLE: no second snapshot; DONE sticky.
        repeat (3) step(0, 1, 0, 1, 36'hfffffffff);
        chk("sticky_done", 36'(DONE), 36'd1);
        step(1, 0, 0, 0, '0);
        chk("arm_clears_done", 36'(DONE), 36'd0);
        step(0, 0, 1, 0, '0);

        // Backpressure: random ready must give the identical sequence.
        snapshot(0, 1);
        check_seq("bp", 0);

        // Abort after 5 transfers, with a same-cycle transfer attempt.
        got_dat.delete();
        got_last.delete();
        step(1, 0, 0, 0, '0);
        for (int k = 0; k < DEPTH; k++) step(0, 1, 0, 0, wk(100, k));
        for (int c = 0; c < 5; c++) step(0, 0, 0, 1, '0);
        step(0, 0, 1, 1, '0);
        chk("abort_valid", 36'(RD_VALID), 36'd0);
        chk("abort_done",  36'(DONE),     36'd0);
        chk("abort_count", 36'(got_dat.size()), 36'd5);

        // Re-arm with new data restarts at sample 0.
        snapshot(200, 0);
        check_seq("rearm", 200);

        // Asynchronous reset in the middle of capture.
        step(1, 0, 0, 0, '0);
        step(0, 1, 0, 0, wk(7, 0));
        step(0, 0, 0, 0, wk(7, 1));
        #0.3;
        RST_N = 1'b0;
        #0.2;
        model_reset();
        compare_outputs();
        repeat (2) @(posedge CLK500M);
        #1;
        RST_N = 1'b1;
        compare_outputs();
        snapshot(50, 1);
        check_seq("post_reset", 50);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 4000; c++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
                 {4'($urandom), 32'($urandom)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
